// File: rtl/status_display_pkg.sv
// Shared constants, FSM encoding and snapshot record for the status display formatter.
package status_display_pkg;

  localparam int unsigned DIG_STATE  = 15;
  localparam int unsigned DIG_SEC_HI = 13;
  localparam int unsigned DIG_SEC_LO = 12;
  localparam int unsigned DIG_PR     = 10;
  localparam int unsigned DIG_SONG   = 8;

  localparam logic [8:0] FIXED_BLANK_MASK = 9'b010010101;

  typedef enum logic [1:0] {
    FMT_IDLE,
    FMT_CONVERT,
    FMT_COMMIT
  } fmt_state_e;

  typedef struct packed {
    logic [1:0]  state;
    logic [7:0]  seconds;
    logic        play_record;
    logic [3:0]  songchoice;
    logic [27:0] effectnums;
    logic [6:0]  effect_valid;
  } snap_t;

  function automatic logic [7:0] clamp_seconds(input logic [7:0] s);
    return (s > 8'd99) ? 8'd99 : s;
  endfunction

endpackage

// File: rtl/status_display_formatter_bcd.sv
// Sequential double-dabble: binary 0..99 to two BCD digits, one shift/add-3 step per clock.
module bin8_to_bcd_seq (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] bin,
  output logic [7:0] bcd,
  output logic       done
);

  logic [15:0] sh_q, sh_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        run_q, run_d;
  logic        done_q, done_d;

  always_comb begin
    sh_d   = sh_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    done_d = 1'b0;
    if (start) begin
      sh_d  = {8'h00, bin};
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (sh_d[8 + 4*i +: 4] >= 4'd5)
          sh_d[8 + 4*i +: 4] = sh_d[8 + 4*i +: 4] + 4'd3;
      end
      sh_d  = {sh_d[14:0], 1'b0};
      cnt_d = cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_q   <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign bcd  = sh_q[15:8];
  assign done = done_q;

endmodule

// File: rtl/status_display_formatter.sv
// Snapshots central-FSM status and formats an atomic 16-digit frame plus cursor blink.
// Optional RECORD_FLASH_EN: record digit flashes with the blink phase while recording.
module status_display_formatter
  import status_display_pkg::*;
#(
  parameter int unsigned BLINK_HALF_PERIOD = 6750000
) (
  input  logic        clock_27mhz,
  input  logic        reset,
  input  logic [1:0]  state,
  input  logic [7:0]  seconds,
  input  logic        play_record,
  input  logic [3:0]  songchoice,
  input  logic [27:0] effectnums,
  input  logic [6:0]  effect_valid,
  input  logic        edit_active,
  input  logic [2:0]  edit_slot,
  output logic [63:0] data,
  output logic [15:0] blank_data,
  output logic [15:0] blink_data,
  output logic        busy
);

  localparam int unsigned CW = $clog2(BLINK_HALF_PERIOD + 1);

  fmt_state_e   fsm_q, fsm_d;
  snap_t        snap_q, snap_d, cur;
  logic         snap_vld_q, snap_vld_d;
  logic [63:0]  data_q, data_d;
  logic [15:0]  blank_q, blank_d;
  logic [15:0]  blink_q, blink_d;
  logic         busy_q, busy_d;
  logic [CW-1:0] bcnt_q, bcnt_d;
  logic         phase_q, phase_d;
  logic         start;
  logic [7:0]   bcd;
  logic         bcd_done;

  assign cur = '{state: state, seconds: seconds, play_record: play_record,
                 songchoice: songchoice, effectnums: effectnums, effect_valid: effect_valid};

  bin8_to_bcd_seq u_bcd (
    .clk   (clock_27mhz),
    .reset (reset),
    .start (start),
    .bin   (clamp_seconds(seconds)),
    .bcd   (bcd),
    .done  (bcd_done)
  );

  // Snapshot holds raw seconds so an out-of-range value does not re-trigger forever.
  always_comb begin
    fsm_d      = fsm_q;
    snap_d     = snap_q;
    snap_vld_d = snap_vld_q;
    data_d     = data_q;
    blank_d    = blank_q;
    busy_d     = busy_q;
    start      = 1'b0;
    unique case (fsm_q)
      FMT_IDLE: begin
        if (!snap_vld_q || (cur != snap_q)) begin
          snap_d     = cur;
          snap_vld_d = 1'b1;
          start      = 1'b1;
          busy_d     = 1'b1;
          fsm_d      = FMT_CONVERT;
        end
      end
      FMT_CONVERT: begin
        if (bcd_done) fsm_d = FMT_COMMIT;
      end
      FMT_COMMIT: begin
        data_d = '0;
        data_d[4*DIG_STATE +: 4]  = {2'b00, snap_q.state};
        data_d[4*DIG_SEC_LO +: 8] = bcd;
        data_d[4*DIG_PR +: 4]     = {3'b000, snap_q.play_record};
        data_d[4*DIG_SONG +: 4]   = snap_q.songchoice;
        data_d[27:0]              = snap_q.effectnums;
        blank_d = {FIXED_BLANK_MASK, ~snap_q.effect_valid};
        busy_d  = 1'b0;
        fsm_d   = FMT_IDLE;
      end
      default: fsm_d = FMT_IDLE;
    endcase
  end

  always_comb begin
    bcnt_d  = bcnt_q + CW'(1);
    phase_d = phase_q;
    if (bcnt_q == CW'(BLINK_HALF_PERIOD - 1)) begin
      bcnt_d  = '0;
      phase_d = ~phase_q;
    end
    blink_d = '0;
    if (edit_active && (edit_slot <= 3'd6))
      blink_d[{1'b0, edit_slot}] = phase_q;
`ifdef RECORD_FLASH_EN
    if (data_q[4*DIG_PR])
      blink_d[DIG_PR] = blink_d[DIG_PR] | phase_q;
`else
`endif
  end

  always_ff @(posedge clock_27mhz) begin
    if (reset) begin
      fsm_q      <= FMT_IDLE;
      snap_q     <= '0;
      snap_vld_q <= 1'b0;
      data_q     <= '0;
      blank_q    <= '1;
      blink_q    <= '0;
      busy_q     <= 1'b0;
      bcnt_q     <= '0;
      phase_q    <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      snap_q     <= snap_d;
      snap_vld_q <= snap_vld_d;
      data_q     <= data_d;
      blank_q    <= blank_d;
      blink_q    <= blink_d;
      busy_q     <= busy_d;
      bcnt_q     <= bcnt_d;
      phase_q    <= phase_d;
    end
  end

  assign data       = data_q;
  assign blank_data = blank_q;
  assign blink_data = blink_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_status_display_formatter.sv
// Randomized bench for status_display_formatter against a frame-level behavioural model.
module tb_status_display_formatter;

  localparam int unsigned HALF = 4;
  localparam int unsigned LAT  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  st = '0;
  logic [7:0]  sec = '0;
  logic        pr = 1'b0;
  logic [3:0]  song = '0;
  logic [27:0] eff = '0;
  logic [6:0]  ev = '0;
  logic        ed_act = 1'b0;
  logic [2:0]  ed_slot = 3'd7;
  logic [63:0] data;
  logic [15:0] blank_data, blink_data;
  logic        busy;

  int total = 0;
  int bad = 0;
  bit check_en = 1'b0;

  status_display_formatter #(.BLINK_HALF_PERIOD(HALF)) dut (
    .clock_27mhz (clk),
    .reset       (reset),
    .state       (st),
    .seconds     (sec),
    .play_record (pr),
    .songchoice  (song),
    .effectnums  (eff),
    .effect_valid(ev),
    .edit_active (ed_act),
    .edit_slot   (ed_slot),
    .data        (data),
    .blank_data  (blank_data),
    .blink_data  (blink_data),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Behavioural model: a frame appears LAT edges after the capture edge.
  logic [63:0] exp_data;
  logic [15:0] exp_blank, exp_blink;
  logic        exp_busy;
  logic [49:0] m_snap;
  bit          m_snap_vld;
  int unsigned m_remain, m_k;

  function automatic logic [63:0] fmt(input logic [49:0] s);
    int unsigned secs;
    logic [63:0] d;
    secs = s[47:40];
    if (secs > 99) secs = 99;
    d = 64'(s[49:48]) << 60;
    d |= 64'(secs / 10) << 52;
    d |= 64'(secs % 10) << 48;
    d |= 64'(s[39]) << 40;
    d |= 64'(s[38:35]) << 32;
    d |= 64'(s[34:7]);
    return d;
  endfunction

  always @(posedge clk) begin
    logic [49:0] cur;
    logic [15:0] nb;
    bit ph;
    cur = {st, sec, pr, song, eff, ev};
    if (reset) begin
      exp_data = '0; exp_blank = 16'hFFFF; exp_blink = '0; exp_busy = 1'b0;
      m_snap_vld = 1'b0; m_remain = 0; m_k = 0;
    end else begin
      ph = ((m_k / HALF) % 2) == 1;
      nb = '0;
      if (ed_act && ed_slot <= 3'd6 && ph) nb[ed_slot] = 1'b1;
`ifdef RECORD_FLASH_EN
      if (exp_data[40] && ph) nb[10] = 1'b1;
`endif
      exp_blink = nb;
      m_k++;
      if (m_remain == 0) begin
        if (!m_snap_vld || cur != m_snap) begin
          m_snap = cur; m_snap_vld = 1'b1; m_remain = LAT; exp_busy = 1'b1;
        end
      end else begin
        m_remain--;
        if (m_remain == 0) begin
          exp_data  = fmt(m_snap);
          exp_blank = {9'b010010101, ~m_snap[6:0]};
          exp_busy  = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("model_data", data, exp_data);
      chk("model_blank", 64'(blank_data), 64'(exp_blank));
      chk("model_blink", 64'(blink_data), 64'(exp_blink));
      chk("model_busy", 64'(busy), 64'(exp_busy));
    end
  end

  task automatic wait_low(output int n);
    n = 0;
    while (busy === 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) chk("busy_timeout", 64'(busy), 64'd0);
  endtask

  initial begin
    int n, ones, ones10;
    logic [15:0] others;
    @(posedge clk);
    check_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_data", data, 64'd0);
    chk("rst_blank", 64'(blank_data), 64'hFFFF);
    chk("rst_blink", 64'(blink_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_recapture", 64'(busy), 64'd1);
    wait_low(n);

    st = 2'd2; sec = 8'd47; song = 4'd5; pr = 1'b1;
    @(negedge clk);
    wait_low(n);
    chk("busy_len", 64'(n), 64'd10);
    chk("dig_state", 64'(data[63:60]), 64'd2);
    chk("dig_sec", 64'(data[55:48]), 64'h47);
    chk("dig_pr", 64'(data[43:40]), 64'd1);
    chk("dig_song", 64'(data[35:32]), 64'd5);

    sec = 8'd150;
    @(negedge clk);
    wait_low(n);
    chk("sec_clamp", 64'(data[55:48]), 64'h99);

    sec = 8'd12;
    repeat (3) @(negedge clk);
    sec = 8'd34;
    wait_low(n);
    chk("first_conv", 64'(data[55:48]), 64'h12);
    @(negedge clk);
    chk("reconvert_start", 64'(busy), 64'd1);
    wait_low(n);
    chk("second_conv", 64'(data[55:48]), 64'h34);

    ev = 7'b0000101; pr = 1'b0;
    @(negedge clk);
    wait_low(n);
    chk("blank_mask", 64'(blank_data), 64'b0100_1010_1111_1010);

    ed_act = 1'b1; ed_slot = 3'd3;
    @(negedge clk);
    ones = 0; others = '0;
    for (int i = 0; i < 16; i++) begin
      ones += int'(blink_data[3]);
      others |= blink_data & ~16'h0008;
      @(negedge clk);
    end
    chk("blink_duty", 64'(ones), 64'd8);
    chk("blink_others", 64'(others), 64'd0);
    ed_slot = 3'd7;
    @(negedge clk);
    others = '0;
    for (int i = 0; i < 8; i++) begin
      others |= blink_data;
      @(negedge clk);
    end
    chk("blink_slot7", 64'(others), 64'd0);
    ed_act = 1'b0;

    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 199) == 0);
      case ($urandom_range(0, 11))
        0: st = 2'($urandom);
        1: sec = 8'($urandom);
        2: pr = 1'($urandom);
        3: song = 4'($urandom);
        4: eff = 28'($urandom);
        5: ev = 7'($urandom);
        6: begin ed_act = 1'($urandom); ed_slot = 3'($urandom); end
        default: ;
      endcase
    end
    reset = 1'b0;
    ed_act = 1'b0;
    @(negedge clk);
    wait_low(n);

    sec = 8'd77;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_data", data, 64'd0);
    chk("midrst_blank", 64'(blank_data), 64'hFFFF);
    chk("midrst_blink", 64'(blink_data), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    wait_low(n);
    chk("midrst_recovery", 64'(data[55:48]), 64'h77);

    pr = 1'b1;
    @(negedge clk);
    wait_low(n);
    ones10 = 0;
    for (int i = 0; i < 16; i++) begin
      ones10 += int'(blink_data[10]);
      @(negedge clk);
    end
`ifdef RECORD_FLASH_EN
    chk("record_flash", 64'(ones10), 64'd8);
`else
    chk("record_flash", 64'(ones10), 64'd0);
`endif

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
